// File: rtl/spk_train_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : spk_train_buffer
//  Purpose  : Ping-pong spike-train buffer between a producer neuron core and
//             the next layer's consumer core. Captures spike rows per time
//             step / channel group, commits full frames, serves random reads.
//  Revision : 1.0  initial release
// ============================================================================
module spk_train_buffer #(
    parameter int TIME_STEPS        = 3,
    parameter int OUT_CHANNELS      = 16,
    parameter int FRAME_WIDTH       = 6,
    parameter int PE_ARRAY_ROW_SIZE = 2
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [PE_ARRAY_ROW_SIZE-1:0][FRAME_WIDTH*FRAME_WIDTH-1:0] wr_spk_arr,
    input  logic                                                   wr_spk_ready,
    input  logic [$clog2(TIME_STEPS):0]                            wr_time_step,
    input  logic [$clog2(OUT_CHANNELS):0]                          wr_oc_phase,
    input  logic                                                   wr_frame_done,
    output logic                                                   wr_bank_free,
    input  logic                                                   rd_en,
    input  logic [$clog2(TIME_STEPS):0]                            rd_time_step,
    input  logic [$clog2(OUT_CHANNELS):0]                          rd_channel,
    input  logic [$clog2(FRAME_WIDTH*FRAME_WIDTH):0]               rd_pixel,
    output logic                                                   rd_valid,
    output logic [FRAME_WIDTH*FRAME_WIDTH-1:0]                     rd_word,
    output logic                                                   rd_spike,
    input  logic                                                   rd_release,
    output logic                                                   pre_syn_RAM_loaded,
    output logic                                                   overflow_err,
    output logic                                                   frame_err,
    output logic                                                   release_err
);

    localparam int c_FW2          = FRAME_WIDTH * FRAME_WIDTH;
    localparam int c_ROWS         = PE_ARRAY_ROW_SIZE;
    localparam int c_PHASES       = OUT_CHANNELS / PE_ARRAY_ROW_SIZE;
    localparam int c_ENTRIES      = TIME_STEPS * OUT_CHANNELS;
    localparam int c_DEPTH        = 2 * c_ENTRIES;
    localparam int c_ADDR_W       = $clog2(c_DEPTH);
    localparam int c_FRAME_PULSES = TIME_STEPS * c_PHASES;
    localparam int c_CNT_W        = $clog2(c_FRAME_PULSES + 1) + 1;
    localparam int c_TS_W         = $clog2(TIME_STEPS) + 1;
    localparam int c_OC_W         = $clog2(OUT_CHANNELS) + 1;
    localparam int c_PIX_W        = $clog2(c_FW2) + 1;

    localparam logic [c_TS_W-1:0]  c_TS_LIM    = c_TS_W'(TIME_STEPS);
    localparam logic [c_OC_W-1:0]  c_PH_LIM    = c_OC_W'(c_PHASES);
    localparam logic [c_OC_W-1:0]  c_CH_LIM    = c_OC_W'(OUT_CHANNELS);
    localparam logic [c_PIX_W-1:0] c_PIX_LIM   = c_PIX_W'(c_FW2);
    localparam logic [c_CNT_W-1:0] c_CNT_FRAME = c_CNT_W'(c_FRAME_PULSES);
    localparam logic [c_ADDR_W-1:0] c_BANK_OFS = c_ADDR_W'(c_ENTRIES);

    // Read-side state machine encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    // Spike storage: bank 0 occupies [0, ENTRIES), bank 1 [ENTRIES, 2*ENTRIES)
    logic [c_FW2-1:0]   r_mem [0:c_DEPTH-1];

    logic [0:0]         r_state;
    logic [1:0]         r_full_cnt;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [c_CNT_W-1:0] r_pulse_cnt;
    logic               r_loaded;
    logic               r_overflow_err;
    logic               r_frame_err;
    logic               r_release_err;
    logic               r_rd_valid;
    logic [c_FW2-1:0]   r_rd_word;
    logic               r_rd_spike;

    logic               w_reading;
    logic               w_wr_free;
    logic               w_wr_in_range;
    logic               w_wr_accept;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_commit_ok;
    logic               w_load;
    logic [c_ADDR_W-1:0] w_wr_addr;
    logic               w_rd_ok;
    logic [c_ADDR_W-1:0] w_rd_addr;
    logic [c_FW2-1:0]   w_rd_data;
    logic [c_FW2-1:0]   w_rd_shift;

    assign w_reading = (r_state == S_READ);

    // A bank is free while fewer than two banks are full or being read
    assign w_wr_free = (({1'b0, r_full_cnt} + {2'b00, w_reading}) < 3'd2);

    assign w_wr_in_range = (wr_time_step < c_TS_LIM) && (wr_oc_phase < c_PH_LIM);
    assign w_wr_accept   = wr_spk_ready && w_wr_free && w_wr_in_range;

    // Counter saturates so a runaway producer cannot wrap back onto a valid count;
    // the write of this cycle is counted before the commit check
    assign w_cnt_inc   = (w_wr_accept && (r_pulse_cnt != {c_CNT_W{1'b1}})) ?
                         r_pulse_cnt + c_CNT_W'(1) : r_pulse_cnt;
    assign w_commit_ok = wr_frame_done && (w_cnt_inc == c_CNT_FRAME);

    assign w_load = (r_state == S_IDLE) && (r_full_cnt != 2'd0);

    // Base address of row 0 of the current pulse in the write bank
    assign w_wr_addr = (r_wr_bank ? c_BANK_OFS : '0)
                     + c_ADDR_W'(wr_time_step) * c_ADDR_W'(OUT_CHANNELS)
                     + c_ADDR_W'(wr_oc_phase) * c_ADDR_W'(c_ROWS);

    assign w_rd_ok = rd_en && w_reading
                   && (rd_time_step < c_TS_LIM)
                   && (rd_channel < c_CH_LIM)
                   && (rd_pixel < c_PIX_LIM);

    assign w_rd_addr = (r_rd_bank ? c_BANK_OFS : '0)
                     + c_ADDR_W'(rd_time_step) * c_ADDR_W'(OUT_CHANNELS)
                     + c_ADDR_W'(rd_channel);

    assign w_rd_data  = r_mem[w_rd_addr];
    assign w_rd_shift = w_rd_data >> rd_pixel;

    // Capture all rows of an accepted pulse in one cycle
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            for (int r = 0; r < c_ROWS; r++) begin
                r_mem[w_wr_addr + c_ADDR_W'(r)] <= wr_spk_arr[r];
            end
        end
    end

    // Write-side bookkeeping: pulse counting, frame commit/discard, write errors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_cnt    <= '0;
            r_wr_bank      <= 1'b0;
            r_overflow_err <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            if (wr_spk_ready && !w_wr_free) begin
                r_overflow_err <= 1'b1;
            end
            if (wr_spk_ready && w_wr_free && !w_wr_in_range) begin
                r_frame_err <= 1'b1;
            end
            if (wr_frame_done) begin
                r_pulse_cnt <= '0;
                if (w_commit_ok) begin
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                r_pulse_cnt <= w_cnt_inc;
            end
        end
    end

    // Read-side FSM: hand full banks to the consumer, one at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_full_cnt    <= 2'd0;
            r_rd_bank     <= 1'b0;
            r_loaded      <= 1'b0;
            r_release_err <= 1'b0;
        end else begin
            r_full_cnt <= r_full_cnt + {1'b0, w_commit_ok} - {1'b0, w_load};
            r_loaded   <= w_load;
            case (r_state)
                S_IDLE: begin
                    if (rd_release) begin
                        r_release_err <= 1'b1;
                    end
                    if (w_load) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_release) begin
                        r_state   <= S_IDLE;
                        r_rd_bank <= ~r_rd_bank;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered read port: one result per requesting cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_word  <= '0;
            r_rd_spike <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_word  <= w_rd_data;
                r_rd_spike <= w_rd_shift[0];
            end
        end
    end

    assign wr_bank_free       = w_wr_free;
    assign rd_valid           = r_rd_valid;
    assign rd_word            = r_rd_word;
    assign rd_spike           = r_rd_spike;
    assign pre_syn_RAM_loaded = r_loaded;
    assign overflow_err       = r_overflow_err;
    assign frame_err          = r_frame_err;
    assign release_err        = r_release_err;

endmodule
`default_nettype wire

// File: doc/spk_train_buffer.md
Name: spk_train_buffer

Overview:
- Post-synaptic spike-train buffer between a conv/dense neuron core (producer) and the next layer's core (consumer).
- Captures each spike row the producer emits, on every new_spk_train_ready pulse, into a ping-pong RAM indexed by time step and output channel.
- Marks a bank readable when the producer signals that its frame is complete.
- Serves random-access spike reads to the consumer and raises the consumer's pre_syn_RAM_loaded.

Parameters:
- TIME_STEPS, 3: spike time steps per frame.
- OUT_CHANNELS, 16: producer output channels.
- FRAME_WIDTH, 6: feature-map width; a row is FRAME_WIDTH*FRAME_WIDTH bits (FW2).
- PE_ARRAY_ROW_SIZE, 2: spike rows delivered per pulse (ROWS).
- Derived PHASES = OUT_CHANNELS/ROWS; ENTRIES = TIME_STEPS*OUT_CHANNELS words of FW2 bits per bank.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_spk_arr  in  ROWS x FW2  producer spike rows
- wr_spk_ready  in  1  one-cycle pulse: wr_spk_arr valid
- wr_time_step  in  $clog2(TIME_STEPS)+1  time step of the rows, valid with wr_spk_ready
- wr_oc_phase  in  $clog2(OUT_CHANNELS)+1  channel group of the rows, valid with wr_spk_ready
- wr_frame_done  in  1  one-cycle pulse: producer finished frame (post_syn_RAM_loaded)
- wr_bank_free  out  1  a bank is available for writing
- rd_en  in  1  read request
- rd_time_step  in  $clog2(TIME_STEPS)+1  read time step
- rd_channel  in  $clog2(OUT_CHANNELS)+1  read channel
- rd_pixel  in  $clog2(FW2)+1  read pixel
- rd_valid  out  1  read data valid
- rd_word  out  FW2  addressed spike row
- rd_spike  out  1  rd_word[rd_pixel]
- rd_release  in  1  pulse: consumer finished with read bank
- pre_syn_RAM_loaded  out  1  one-cycle pulse to consumer: bank readable
- overflow_err  out  1  sticky: write dropped, no free bank
- frame_err  out  1  sticky: frame committed with a wrong pulse count
- release_err  out  1  sticky: release with no bank being read

Behaviour:
- Reset:
  - All outputs 0, except wr_bank_free = 1.
  - wr_bank = 0, rd_bank = 0, full_cnt = 0, reading = 0, pulse counter = 0.
  - RAM contents are not cleared.
- Write path:
  - On wr_spk_ready while wr_bank_free, write row r (0..ROWS-1) to wr_bank at address wr_time_step*OUT_CHANNELS + wr_oc_phase*ROWS + r.
  - All ROWS rows are written in the same cycle.
  - The pulse counter increments on each accepted write.
- wr_spk_ready while !wr_bank_free: write dropped, overflow_err set.
- Out-of-range wr_time_step or wr_oc_phase (>= TIME_STEPS or >= PHASES): write dropped, frame_err set.
- Commit, on wr_frame_done:
  - If the pulse counter == TIME_STEPS*PHASES: full_cnt++, wr_bank toggles.
  - Otherwise: frame_err set and the bank is discarded; counter cleared, bank stays the write bank.
  - The pulse counter clears in both cases.
- wr_bank_free = (full_cnt + reading) < 2.
- Read-side FSM, states IDLE and READ:
  - IDLE -> READ when full_cnt > 0. That cycle: pre_syn_RAM_loaded = 1 for exactly one cycle, reading = 1, full_cnt--.
  - READ -> IDLE on rd_release. That cycle: rd_bank toggles, reading = 0.
  - A second full bank triggers a fresh pulse only after re-entering IDLE, with at least one IDLE cycle between pulses.
  - rd_release in IDLE: ignored, release_err set.
- Reads:
  - rd_en in READ: rd_valid, rd_word and rd_spike are registered one cycle later from rd_bank at rd_time_step*OUT_CHANNELS + rd_channel.
  - Back-to-back rd_en gives one result per cycle.
  - rd_en in IDLE or with out-of-range indices: rd_valid = 0 next cycle, no error.
  - rd_valid is otherwise 0.
- Simultaneous events:
  - Commit and release in the same cycle: both apply; full_cnt and reading are updated consistently, and wr_bank_free follows next cycle.
  - wr_spk_ready and wr_frame_done in the same cycle: the write is counted before the commit check.
- Reset mid-frame or mid-read: everything returns to the reset state; no pre_syn_RAM_loaded pulse is emitted; sticky errors clear.

Test Plan:
- Single frame, defaults:
  - Stimulus: 24 pulses (3 ts x 8 phases), each row = {ts, phase, r} pattern, then frame_done.
  - Response: pre_syn_RAM_loaded pulse 1 cycle after commit.
  - Response: reading (ts=2, ch=15) returns the phase-7 row-1 pattern 1 cycle after rd_en; rd_spike matches bit rd_pixel.
- Ping-pong:
  - Stimulus: write frames A and B without release.
  - Response: wr_bank_free = 0 after B commits; a 25th pulse sets overflow_err.
  - Stimulus: rd_release.
  - Response: second pre_syn_RAM_loaded pulse; reads now return B data.
- Short frame:
  - Stimulus: 23 pulses then frame_done.
  - Response: frame_err = 1, no loaded pulse, full_cnt stays 0.
  - Response: a following 24-pulse frame commits normally.
- Same-cycle events:
  - Stimulus: commit frame B in the same cycle as releasing A.
  - Response: loaded pulse for B after one IDLE cycle; wr_bank_free = 1 throughout.
- Release and invalid reads:
  - Stimulus: rd_release with nothing loaded. Response: release_err = 1.
  - Stimulus: rd_en in IDLE. Response: rd_valid stays 0.
- Reset mid-read:
  - Stimulus: assert rst during READ.
  - Response: all flags 0, wr_bank_free = 1, no spurious loaded pulse afterward.
